// File: rtl/id_decode_stage.sv
// RV32I decode stage: instr/pc -> ALU op, immediate and control bundle, 1-cycle latency.
// Registered 2-entry skid (M drives outputs, S catches overflow); in_ready = S empty, no out_ready->in_ready path.
module id_decode_stage #(
  parameter int          XLEN       = 32,
  parameter logic [3:0]  ILLEGAL_OP = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [1:0]      src2_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] pc_out,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            branch_ne,
  output logic            jump,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [1:0]      src2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_ne;
    logic            jump;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  bundle_t    dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rd_addr  = instr[11:7];
    dec.pc       = pc;
    case (opcode)
      OPC_R: begin
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = (funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
          3'b001:  dec.alu_op = OP_SLL;
          3'b010:  dec.alu_op = OP_SLT;
          3'b100:  dec.alu_op = OP_XOR;
          3'b101:  dec.alu_op = OP_SRL;
          3'b110:  dec.alu_op = OP_OR;
          3'b111:  dec.alu_op = OP_AND;
          default: legal = 1'b0;
        endcase
        // Only add/sub distinguishes funct7; every other R-type needs it zero.
        if (!(funct7 == 7'b0 || (funct3 == 3'b000 && funct7 == 7'b0100000))) legal = 1'b0;
      end
      OPC_I: begin
        dec.reg_write = 1'b1;
        dec.src2_sel  = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000:  dec.alu_op = OP_ADD;
          3'b001:  dec.alu_op = OP_SLL;
          3'b010:  dec.alu_op = OP_SLT;
          3'b100:  dec.alu_op = OP_XOR;
          3'b101:  dec.alu_op = OP_SRL;
          3'b110:  dec.alu_op = OP_OR;
          3'b111:  dec.alu_op = OP_AND;
          default: legal = 1'b0;
        endcase
        if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0) legal = 1'b0;
      end
      OPC_LD: begin
        dec.alu_op    = OP_ADD;
        dec.src2_sel  = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:20]};
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        if (funct3 != 3'b010) legal = 1'b0;
      end
      OPC_ST: begin
        dec.alu_op    = OP_ADD;
        dec.src2_sel  = 2'd1;
        dec.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.mem_write = 1'b1;
        if (funct3 != 3'b010) legal = 1'b0;
      end
      OPC_BR: begin
        dec.alu_op    = OP_SUB;
        dec.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.branch    = 1'b1;
        dec.branch_ne = funct3[0];
        if (funct3[2:1] != 2'b00) legal = 1'b0;
      end
      OPC_JAL: begin
        dec.alu_op    = OP_JAL;
        dec.src2_sel  = 2'd2;
        dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op    = OP_LUI;
        dec.src2_sel  = 2'd1;
        dec.imm       = {12'b0, instr[31:12]};
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alu_op    = ILLEGAL_OP;
      dec.src2_sel  = 2'd0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.branch_ne = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  bundle_t m_q, m_d, s_q, s_d;
  logic    m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic    accept, fire;

  assign accept = in_valid & ~s_vld_q;
  assign fire   = m_vld_q & out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (s_vld_q) begin
      // S full means in_ready is low, so only the drain into M can happen.
      if (fire) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_vld_q || fire) begin
        m_d     = dec;
        m_vld_d = 1'b1;
      end else begin
        s_d     = dec;
        s_vld_d = 1'b1;
      end
    end else if (fire) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign in_ready  = ~s_vld_q;
  assign out_valid = m_vld_q;
  assign alu_op    = m_q.alu_op;
  assign src2_sel  = m_q.src2_sel;
  assign imm       = m_q.imm;
  assign rs1_addr  = m_q.rs1_addr;
  assign rs2_addr  = m_q.rs2_addr;
  assign rd_addr   = m_q.rd_addr;
  assign pc_out    = m_q.pc;
  assign reg_write = m_q.reg_write;
  assign mem_read  = m_q.mem_read;
  assign mem_write = m_q.mem_write;
  assign branch    = m_q.branch;
  assign branch_ne = m_q.branch_ne;
  assign jump      = m_q.jump;
  assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, skid backpressure, flush and reset.
module tb_id_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [1:0]  src2_sel;
  logic [31:0] imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] pc_out;
  logic        reg_write, mem_read, mem_write, branch, branch_ne, jump, illegal;

  int checks = 0;
  int fails  = 0;

  id_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .src2_sel(src2_sel), .imm(imm), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rd_addr(rd_addr), .pc_out(pc_out), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne),
    .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    // Inputs are driven during reset and must be ignored.
    offer(32'h002081B3, 32'h0000_0040);
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_op", alu_op, 0);
    check("rst_imm", imm, 0);
    check("rst_reg_write", reg_write, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    offer(32'h002081B3, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    check("add_out_valid", out_valid, 1);
    check("add_alu_op", alu_op, 4'b0001);
    check("add_rs1", rs1_addr, 1);
    check("add_rs2", rs2_addr, 2);
    check("add_rd", rd_addr, 3);
    check("add_src2_sel", src2_sel, 0);
    check("add_reg_write", reg_write, 1);
    check("add_pc_out", pc_out, 32'h0000_0100);
    check("add_illegal", illegal, 0);
    tick();
    check("add_drained", out_valid, 0);

    // addi then lui back to back, one per cycle
    offer(32'hFFF00293, 32'h0000_0104);
    tick();
    check("addi_alu_op", alu_op, 4'b0001);
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_src2_sel", src2_sel, 1);
    check("addi_rd", rd_addr, 5);
    offer(32'h123450B7, 32'h0000_0108);
    tick();
    in_valid = 1'b0;
    check("lui_out_valid", out_valid, 1);
    check("lui_alu_op", alu_op, 4'b1010);
    check("lui_imm", imm, 32'h0001_2345);
    check("lui_rd", rd_addr, 1);
    check("lui_reg_write", reg_write, 1);

    // beq x1,x2,-4
    offer(32'hFE208EE3, 32'h0000_010C);
    tick();
    in_valid = 1'b0;
    check("beq_alu_op", alu_op, 4'b0010);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    check("beq_branch", branch, 1);
    check("beq_branch_ne", branch_ne, 0);
    check("beq_reg_write", reg_write, 0);
    check("beq_src2_sel", src2_sel, 0);

    // sw x2,8(x1)
    offer(32'h0020A423, 32'h0000_0110);
    tick();
    in_valid = 1'b0;
    check("sw_alu_op", alu_op, 4'b0001);
    check("sw_imm", imm, 32'h0000_0008);
    check("sw_mem_write", mem_write, 1);
    check("sw_reg_write", reg_write, 0);

    // jal x1,-8
    offer(32'hFF9FF0EF, 32'h0000_0114);
    tick();
    in_valid = 1'b0;
    check("jal_alu_op", alu_op, 4'b1001);
    check("jal_imm", imm, 32'hFFFF_FFF8);
    check("jal_src2_sel", src2_sel, 2);
    check("jal_jump", jump, 1);
    check("jal_reg_write", reg_write, 1);
    tick();

    // Backpressure: A=add, B=sub, C=xor offered back to back with out_ready low
    out_ready = 1'b0;
    offer(32'h002081B3, 32'h0000_0200);
    tick();
    check("bp_a_in_ready", in_ready, 1);
    offer(32'h402081B3, 32'h0000_0204);
    tick();
    check("bp_full_in_ready", in_ready, 0);
    offer(32'h0020C1B3, 32'h0000_0208);
    tick();
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_alu_op", alu_op, 4'b0001);
    check("bp_hold_pc", pc_out, 32'h0000_0200);
    out_ready = 1'b1;
    tick();
    check("bp_b_alu_op", alu_op, 4'b0010);
    check("bp_b_pc", pc_out, 32'h0000_0204);
    check("bp_b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_c_valid", out_valid, 1);
    check("bp_c_alu_op", alu_op, 4'b0111);
    check("bp_c_pc", pc_out, 32'h0000_0208);
    tick();
    check("bp_empty", out_valid, 0);

    // Flush with M and S full plus a bundle offered in the flush cycle
    out_ready = 1'b0;
    offer(32'h002081B3, 32'h0000_0300);
    tick();
    offer(32'h402081B3, 32'h0000_0304);
    tick();
    check("fl_pre_in_ready", in_ready, 0);
    flush = 1'b1;
    offer(32'h0020C1B3, 32'h0000_0308);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("fl_stays_empty1", out_valid, 0);
    tick();
    check("fl_stays_empty2", out_valid, 0);

    // Illegal encodings still flow downstream
    offer(32'hFFFF_FFFF, 32'h0000_0400);
    tick();
    check("ill_ff_valid", out_valid, 1);
    check("ill_ff_alu_op", alu_op, 4'b0000);
    check("ill_ff_illegal", illegal, 1);
    check("ill_ff_reg_write", reg_write, 0);
    offer(32'h4010D093, 32'h0000_0404);
    tick();
    in_valid = 1'b0;
    check("ill_srai_alu_op", alu_op, 4'b0000);
    check("ill_srai_illegal", illegal, 1);
    check("ill_srai_reg_write", reg_write, 0);
    check("ill_srai_pc", pc_out, 32'h0000_0404);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    offer(32'h002081B3, 32'h0000_0500);
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_alu_op", alu_op, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_after_valid", out_valid, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
